sqrt_table_loader: RTL and testbench

- Writer side of the 1024 x 36-bit sqrt lookup table that the FPU sqrt unit reads combinationally.
- Receives the table image as a byte stream, typically from the UART receiver during boot.
- Assembles each 36-bit entry and issues one write per entry into the table RAM, from address 0 upward.
- Replaces the simulation-only file preload, so the table can be (re)loaded at run time on hardware.

---
 rtl/sqrt_table_loader.sv | 141 ++++++++++++++
 tb/tb_sqrt_table_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sqrt_table_loader.sv
// sqrt_table_loader: turns a little-endian byte stream into DATA_W-bit sqrt table writes, address 0 upward.
// Define SQRT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHECK state, err output).
module sqrt_table_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int NBYTES = (DATA_W + 7) / 8;
  localparam int CW = $clog2(NBYTES);
  localparam int AW = (NBYTES - 1) * 8;
  localparam int TW = DATA_W - AW;
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
`ifdef SQRT_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic we_q, we_d, done_q, done_d, last_wr, take;
`ifdef SQRT_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign we = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign done = done_q;
  // Holding in_ready low during the final write keeps stray bytes out of a finished table.
  assign last_wr = we_q && waddr_q == '1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    acc_d = acc_q;
    we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d = done_q;
    busy = state_q != IDLE && state_q != DONE;
    in_ready = state_q == LOAD && !last_wr;
`ifdef SQRT_LOADER_CHECKSUM_EN
    xor_d = xor_q;
    err_d = err_q;
    if (state_q == CHECK) in_ready = 1'b1;
`endif
    take = in_valid && in_ready;
    if (state_q == IDLE || state_q == DONE) begin
      if (start) begin
        state_d = LOAD;
        cnt_d = '0;
        addr_d = '0;
        done_d = 1'b0;
`ifdef SQRT_LOADER_CHECKSUM_EN
        xor_d = '0;
        err_d = 1'b0;
`endif
      end
    end else if (state_q == LOAD) begin
      if (last_wr) begin
`ifdef SQRT_LOADER_CHECKSUM_EN
        state_d = CHECK;
`else
        state_d = DONE;
        done_d = 1'b1;
`endif
      end
      if (take) begin
        cnt_d = cnt_q == CW'(NBYTES - 1) ? '0 : cnt_q + 1'b1;
        for (int k = 0; k < NBYTES - 1; k++)
          if (cnt_q == CW'(k)) acc_d[k*8 +: 8] = in_data;
        if (cnt_q == CW'(NBYTES - 1)) begin
          we_d = 1'b1;
          waddr_d = addr_q;
          wdata_d = {in_data[TW-1:0], acc_q};
          addr_d = addr_q + 1'b1;
        end
`ifdef SQRT_LOADER_CHECKSUM_EN
        xor_d = xor_q ^ in_data;
`endif
      end
    end
`ifdef SQRT_LOADER_CHECKSUM_EN
    else if (take) begin
      state_d = DONE;
      done_d = 1'b1;
      err_d = in_data != xor_q;
    end
`endif
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      acc_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      acc_q <= acc_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q <= done_d;
    end
`ifdef SQRT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      xor_q <= '0;
      err_q <= 1'b0;
    end else begin
      xor_q <= xor_d;
      err_q <= err_d;
    end
`endif
endmodule

// File: tb/tb_sqrt_table_loader.sv
// tb_sqrt_table_loader: random byte streams against an entry-level table model; follows SQRT_LOADER_CHECKSUM_EN.
module tb_sqrt_table_loader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 36;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB = 5 * DEPTH;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, we, busy, done, err;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [7:0] stream[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int n_tests = 0, n_fail = 0, cyc;
  sqrt_table_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (we) begin
      wr_addr.push_back(waddr);
      wr_data.push_back(wdata);
    end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DATA_W-1:0] entry(input int k);
    return {stream[5*k+4][3:0], stream[5*k+3], stream[5*k+2], stream[5*k+1], stream[5*k]};
  endfunction
  function automatic logic [7:0] stream_xor();
    logic [7:0] x = '0;
    for (int i = 0; i < NB; i++) x ^= stream[i];
    return x;
  endfunction
  task automatic gen(input bit zeros);
    stream.delete();
    for (int i = 0; i < NB; i++) stream.push_back(zeros ? 8'h00 : 8'($urandom));
    wr_addr.delete();
    wr_data.delete();
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic push(input int from, input int n, input int stall, output int cycles);
    int i;
    logic took;
    i = from;
    cycles = 0;
    while (i < from + n) begin
      in_valid = $urandom_range(99) >= stall;
      in_data = in_valid ? stream[i] : 8'($urandom);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      cycles++;
      if (took) i++;
      if (cycles > 8 * n + 64) begin
        check("push_timeout", 64'(i), 64'(from + n));
        break;
      end
    end
    in_valid = 1'b0;
  endtask
  task automatic end_load(input string tag, input bit bad);
    int c;
    check({tag, "_last_we"}, we, 1);
    check({tag, "_last_waddr"}, waddr, DEPTH - 1);
    @(posedge clk); #1;
`ifdef SQRT_LOADER_CHECKSUM_EN
    check({tag, "_check_busy"}, busy, 1);
    check({tag, "_check_done"}, done, 0);
    stream.push_back(stream_xor() ^ {7'b0, bad});
    push(NB, 1, 0, c);
    check({tag, "_err"}, err, bad);
`else
    check({tag, "_err"}, err, 0);
`endif
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_we_after"}, we, 0);
    in_valid = 1'b1;
    in_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_hold"}, done, 1);
    check({tag, "_rdy_done"}, in_ready, 0);
    in_valid = 1'b0;
  endtask
  task automatic verify(input string tag, input int n);
    int nbad = 0;
    check({tag, "_nwr"}, 64'(wr_addr.size()), 64'(n));
    for (int k = 0; k < n && k < wr_addr.size(); k++)
      if (wr_addr[k] !== ADDR_W'(k) || wr_data[k] !== entry(k)) nbad++;
    check({tag, "_bad_entries"}, 64'(nbad), 0);
    check({tag, "_first_data"}, wr_data[0], entry(0));
    check({tag, "_last_addr"}, wr_addr[n-1], n - 1);
  endtask
  initial begin
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 0);
    check("idle_busy", busy, 0);
    in_valid = 1'b0;
    // A: single-entry shape, then the rest back-to-back with no bubbles
    gen(0);
    stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h03; stream[3] = 8'h04; stream[4] = 8'hAF;
    pulse_start();
    check("a_busy", busy, 1);
    check("a_in_ready", in_ready, 1);
    check("a_done_clr", done, 0);
    push(0, 5, 0, cyc);
    check("a_we0", we, 1);
    check("a_waddr0", waddr, 0);
    check("a_wdata0", wdata, 36'hF04030201);
    push(5, NB - 5, 0, cyc);
    check("a_b2b_cycles", 64'(cyc), 64'(NB - 5));
    end_load("a", 0);
    verify("a", DEPTH);
    // B: random stalls
    gen(0);
    pulse_start();
    check("b_done_clr", done, 0);
    push(0, NB, 40, cyc);
    end_load("b", 0);
    verify("b", DEPTH);
    // C: stray start mid-load, then reset at entry 300 byte 2 and reload
    gen(0);
    pulse_start();
    push(0, 500, 20, cyc);
    pulse_start();
    check("c_busy_after_start", busy, 1);
    push(500, 1002, 20, cyc);
    verify("c_pre", 300);
    rstn = 1'b0;
    #1;
    check("c_rst_busy", busy, 0);
    check("c_rst_waddr", waddr, 0);
    check("c_rst_wdata", wdata, 0);
    check("c_rst_ready", in_ready, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    gen(0);
    pulse_start();
    push(0, NB, 0, cyc);
    check("c_b2b_cycles", 64'(cyc), 64'(NB));
    end_load("c", 0);
    verify("c", DEPTH);
`ifdef SQRT_LOADER_CHECKSUM_EN
    // D: all-zero table with good then bad checksum
    gen(1);
    pulse_start();
    push(0, NB, 10, cyc);
    end_load("d_good", 0);
    gen(1);
    pulse_start();
    push(0, NB, 10, cyc);
    end_load("d_bad", 1);
    pulse_start();
    check("d_start_done", done, 0);
    check("d_start_err", err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
